// File: rtl/float_widen.sv
// float_widen: IEEE-754 widening converter, stb/ack in and out.
// Subnormals are normalised one bit per cycle before packing.
module float_widen #(
  parameter int EXP_IN    = 8,
  parameter int MAN_IN    = 23,
  parameter int EXP_OUT   = 11,
  parameter int MAN_OUT   = 52,
  parameter bit QUIET_NAN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [EXP_IN+MAN_IN:0]   input_a,
  input  logic                     input_a_stb,
  output logic                     input_a_ack,
  output logic [EXP_OUT+MAN_OUT:0] output_z,
  output logic                     output_z_stb,
  input  logic                     output_z_ack
);

  localparam int IW = 1 + EXP_IN + MAN_IN;
  localparam int OW = 1 + EXP_OUT + MAN_OUT;
  localparam int EW = EXP_OUT + 1;
  localparam int SH = MAN_OUT - MAN_IN;

  localparam logic signed [EW-1:0] BIAS_IN =
    EW'(2**(EXP_IN-1) - 1);
  localparam logic signed [EW-1:0] BIAS_OUT =
    EW'(2**(EXP_OUT-1) - 1);
  localparam logic signed [EW-1:0] E_SUB =
    EW'(2 - 2**(EXP_IN-1));
  localparam logic signed [EW-1:0] ONE = EW'(1);

  if (EXP_OUT <= EXP_IN) begin : g_bad_exp
    $error("float_widen: EXP_OUT must exceed EXP_IN");
  end
  if (MAN_OUT < MAN_IN) begin : g_bad_man
    $error("float_widen: MAN_OUT must be >= MAN_IN");
  end

  typedef enum logic [2:0] {
    GET_A,
    UNPACK,
    NORMALISE,
    PACK,
    PUT_Z
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         a_q, a_d;
  logic signed [EW-1:0]  e_q, e_d;
  logic [MAN_IN:0]       m_q, m_d;
  logic [OW-1:0]         z_q, z_d;
  logic                  ack_q, ack_d;
  logic                  stb_q, stb_d;

  logic                  a_s;
  logic [EXP_IN-1:0]     a_e;
  logic [MAN_IN-1:0]     a_m;
  logic                  e_max;
  logic                  e_zero;
  logic                  m_zero;
  logic signed [EW-1:0]  e_unb;
  logic signed [EW-1:0]  e_bsd;
  logic [MAN_OUT-1:0]    man_fin;
  logic [MAN_OUT-1:0]    man_nan;

  // Field split and pack helpers from the latched operand
  always_comb begin
    a_s     = a_q[IW-1];
    a_e     = a_q[IW-2 -: EXP_IN];
    a_m     = a_q[MAN_IN-1:0];
    e_max   = &a_e;
    e_zero  = ~|a_e;
    m_zero  = ~|a_m;
    e_unb   = signed'({{(EW-EXP_IN){1'b0}}, a_e})
              - BIAS_IN;
    e_bsd   = e_q + BIAS_OUT;
    man_fin = MAN_OUT'(m_q[MAN_IN-1:0]) << SH;
    man_nan = MAN_OUT'(a_m) << SH;
    if (QUIET_NAN) begin
      man_nan[MAN_OUT-1] = 1'b1;
    end
  end

  // Next-state and datapath for the conversion FSM
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    e_d     = e_q;
    m_d     = m_q;
    z_d     = z_q;
    ack_d   = ack_q;
    stb_d   = stb_q;
    unique case (state_q)
      GET_A: begin
        ack_d = 1'b1;
        if (ack_q && input_a_stb) begin
          a_d     = input_a;
          ack_d   = 1'b0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        state_d = PACK;
        unique case (1'b1)
          e_max: begin
          end
          e_zero && m_zero: begin
          end
          e_zero && !m_zero: begin
            e_d     = E_SUB;
            m_d     = {1'b0, a_m};
            state_d = NORMALISE;
          end
          default: begin
            e_d = e_unb;
            m_d = {1'b1, a_m};
          end
        endcase
      end
      NORMALISE: begin
        if (m_q[MAN_IN]) begin
          state_d = PACK;
        end else begin
          m_d = m_q << 1;
          e_d = e_q - ONE;
        end
      end
      PACK: begin
        state_d = PUT_Z;
        unique case (1'b1)
          e_max && m_zero:
            z_d = {a_s, {EXP_OUT{1'b1}},
                   {MAN_OUT{1'b0}}};
          e_max && !m_zero:
            z_d = {a_s, {EXP_OUT{1'b1}}, man_nan};
          e_zero && m_zero:
            z_d = {a_s, {EXP_OUT{1'b0}},
                   {MAN_OUT{1'b0}}};
          default:
            z_d = {a_s, e_bsd[EXP_OUT-1:0],
                   man_fin};
        endcase
      end
      PUT_Z: begin
        stb_d = 1'b1;
        if (stb_q && output_z_ack) begin
          stb_d   = 1'b0;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= GET_A;
      a_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      z_q     <= '0;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      e_q     <= e_d;
      m_q     <= m_d;
      z_q     <= z_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
    end
  end

  assign input_a_ack  = ack_q;
  assign output_z     = z_q;
  assign output_z_stb = stb_q;

endmodule

// File: tb/tb_float_widen.sv
// tb_float_widen: scoreboard bench for float_widen.
// Three builds: default, QUIET_NAN=0, half-to-single.
module tb_float_widen;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;

  logic [31:0] a0, a1;
  logic [15:0] a2;
  logic        s0, s1, s2;
  logic        ack0, ack1, ack2;
  logic [63:0] z0, z1;
  logic [31:0] z2;
  logic        zs0, zs1, zs2;
  logic        zack0, zack1, zack2;

  wire  [2:0]  av = {ack2, ack1, ack0};
  wire  [2:0]  sv = {zs2, zs1, zs0};
  logic [63:0] zv [3];
  assign zv[0] = z0;
  assign zv[1] = z1;
  assign zv[2] = {32'h0, z2};

  typedef struct {
    logic [63:0] z;
    int          lat;
    int          acc;
  } sb_t;

  sb_t  sbq [3][$];
  logic prev [3];

  float_widen u0 (
    .clk(clk), .rst(rst),
    .input_a(a0), .input_a_stb(s0),
    .input_a_ack(ack0),
    .output_z(z0), .output_z_stb(zs0),
    .output_z_ack(zack0)
  );

  float_widen #(.QUIET_NAN(1'b0)) u1 (
    .clk(clk), .rst(rst),
    .input_a(a1), .input_a_stb(s1),
    .input_a_ack(ack1),
    .output_z(z1), .output_z_stb(zs1),
    .output_z_ack(zack1)
  );

  float_widen #(
    .EXP_IN(5), .MAN_IN(10),
    .EXP_OUT(8), .MAN_OUT(23),
    .QUIET_NAN(1'b1)
  ) u2 (
    .clk(clk), .rst(rst),
    .input_a(a2), .input_a_stb(s2),
    .input_a_ack(ack2),
    .output_z(z2), .output_z_stb(zs2),
    .output_z_ack(zack2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare each new result against the scoreboard
  always @(negedge clk) begin
    sb_t e;
    for (int d = 0; d < 3; d++) begin
      if (sv[d] && !prev[d]) begin
        checks++;
        if (sbq[d].size() == 0) begin
          fails++;
          $display("FAIL unexpected_out dut%0d got=%h",
                   d, zv[d]);
        end else begin
          e = sbq[d].pop_front();
          if (zv[d] !== e.z) begin
            fails++;
            $display("FAIL value dut%0d got=%h exp=%h",
                     d, zv[d], e.z);
          end
          if (e.lat > 0) begin
            checks++;
            if (cyc - e.acc != e.lat) begin
              fails++;
              $display("FAIL latency dut%0d got=%0d exp=%0d",
                       d, cyc - e.acc, e.lat);
            end
          end
        end
      end
      prev[d] = sv[d];
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic send(input int d,
                      input logic [63:0] a,
                      input logic [63:0] ez,
                      input int lat,
                      input bit push);
    int n;
    @(negedge clk);
    case (d)
      0: begin a0 = a[31:0]; s0 = 1'b1; end
      1: begin a1 = a[31:0]; s1 = 1'b1; end
      default: begin a2 = a[15:0]; s2 = 1'b1; end
    endcase
    n = 0;
    while (!av[d] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout dut%0d got=0 exp=1", d);
    end else if (push) begin
      sbq[d].push_back('{ez, lat, cyc + 1});
    end
    @(posedge clk);
    #1;
    s0 = 1'b0;
    s1 = 1'b0;
    s2 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq[0].size() + sbq[1].size()
            + sbq[2].size()) != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout got=%0d exp=0",
               sbq[0].size() + sbq[1].size()
               + sbq[2].size());
    end
  endtask

  initial begin
    int n;
    for (int d = 0; d < 3; d++) prev[d] = 1'b0;
    rst = 1'b0;
    a0 = '0; a1 = '0; a2 = '0;
    s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
    zack0 = 1'b1; zack1 = 1'b1; zack2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack", 64'(ack0), 64'd0);
    chk("rst_stb", 64'(zs0), 64'd0);
    chk("rst_z", z0, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ack_after_rst", 64'(ack0), 64'd1);

    send(0, 64'h3F800000, 64'h3FF0000000000000, 3, 1);
    send(0, 64'hC0490FDB, 64'hC00921FB60000000, 3, 1);
    send(0, 64'h80000000, 64'h8000000000000000, 3, 1);
    send(0, 64'h7F800000, 64'h7FF0000000000000, 3, 1);
    send(0, 64'hFF800000, 64'hFFF0000000000000, 3, 1);
    send(0, 64'h7FC00001, 64'h7FF8000020000000, 3, 1);
    send(0, 64'h7F800001, 64'h7FF8000020000000, 3, 1);
    send(0, 64'h00000001, 64'h36A0000000000000, 27, 1);
    send(0, 64'h00400000, 64'h3800000000000000, 5, 1);
    send(1, 64'h7F800001, 64'h7FF0000020000000, 3, 1);
    send(1, 64'h3F800000, 64'h3FF0000000000000, 3, 1);
    send(2, 64'h3C00, 64'h3F800000, 3, 1);
    send(2, 64'h0001, 64'h33800000, 14, 1);
    send(2, 64'h7C01, 64'h7FC02000, 3, 1);
    send(2, 64'hFC00, 64'hFF800000, 3, 1);
    drain();

    zack0 = 1'b0;
    send(0, 64'hC0490FDB, 64'hC00921FB60000000, 3, 1);
    n = 0;
    while (!zs0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_stb_seen", 64'(zs0), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_z", z0, 64'hC00921FB60000000);
      chk("bp_stb", 64'(zs0), 64'd1);
      chk("bp_in_ack", 64'(ack0), 64'd0);
    end
    zack0 = 1'b1;
    @(negedge clk);
    zack0 = 1'b0;
    chk("bp_stb_drop", 64'(zs0), 64'd0);
    @(negedge clk);
    chk("bp_ack_back", 64'(ack0), 64'd1);
    zack0 = 1'b1;
    send(0, 64'h00400000, 64'h3800000000000000, 5, 1);
    drain();

    send(0, 64'h00000001, 64'h0, 0, 0);
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_stb", 64'(zs0), 64'd0);
    chk("abort_ack", 64'(ack0), 64'd0);
    chk("abort_z", z0, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ack_after_abort", 64'(ack0), 64'd1);
    send(0, 64'h3F800000, 64'h3FF0000000000000, 3, 1);
    drain();
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
